// File: rtl/rack_jtag_tap_tracker.sv
// Purpose: passive shadow of the 1149.1 TAP driven by the rack JTAG shift-register
//          engine; records shifted TDI/TDO bits, shift and update counts.
// Latency: one wb_clk per TCK rising edge; Wishbone ack and read data one cycle after select.
// Backpressure: none. The tracker never stalls the engine. A held strobe is acked every other cycle.
//
// Ports:
//   wb_clk, wb_rst           - system clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i     - Wishbone target request (2-bit word address)
//   wb_dat_o, wb_ack_o       - registered read data and single-cycle acknowledge
//   wb_err_o, wb_rty_o       - always 0
//   sr_clk_i                 - TCK from the engine, sampled in the wb_clk domain
//   sr_tms_i/tdi_i/tdo_i     - TMS, TDI and TDO of the selected module
//
// Register map:
//   0 RO status  [3:0] tap_state, [4] last_ir, [15:8] upd_cnt, [31:16] bit_cnt
//   1 RO tdi_cap (LSB-first, most recent bit at [31])
//   2 RO tdo_cap
//   3 WO control (needs wb_sel_i[0]): bit0 force TLR, bit1 clear captures/counters; reads as 0

module rack_jtag_tap_tracker #(
    parameter int CNT_BITS = 16,
    parameter int UPD_BITS = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    input  logic        sr_clk_i,
    input  logic        sr_tms_i,
    input  logic        sr_tdi_i,
    input  logic        sr_tdo_i
);

    // Encoding matches the conventional 1149.1 state codes so that software
    // can decode the status field with standard tables.
    typedef enum logic [3:0] {
        ST_EX2DR = 4'h0,
        ST_EX1DR = 4'h1,
        ST_SHDR  = 4'h2,
        ST_PSDR  = 4'h3,
        ST_SELIR = 4'h4,
        ST_UPDDR = 4'h5,
        ST_CAPDR = 4'h6,
        ST_SELDR = 4'h7,
        ST_EX2IR = 4'h8,
        ST_EX1IR = 4'h9,
        ST_SHIR  = 4'hA,
        ST_PSIR  = 4'hB,
        ST_RTI   = 4'hC,
        ST_UPDIR = 4'hD,
        ST_CAPIR = 4'hE,
        ST_TLR   = 4'hF
    } tap_state_t;

    tap_state_t          r_tap_state;
    tap_state_t          w_tap_next;
    logic                r_clk_prev;
    logic [31:0]         r_tdi_cap;
    logic [31:0]         r_tdo_cap;
    logic [CNT_BITS-1:0] r_bit_cnt;
    logic [UPD_BITS-1:0] r_upd_cnt;
    logic                r_last_ir;

    logic                w_tck_rise;
    logic                w_select;
    logic                w_ctl_wr;
    logic                w_shifting;
    logic                w_enter_cap;
    logic                w_enter_upd;
    logic [31:0]         w_status;
    logic [31:0]         w_rd_dat;
    logic                w_unused;

    // clk_prev resets high, so a TCK already high at reset release is not an edge.
    assign w_tck_rise  = sr_clk_i & ~r_clk_prev;

    // Excluding the ack cycle makes a held strobe alternate select/ack.
    assign w_select    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_ctl_wr    = w_select & wb_we_i & (wb_adr_i == 2'd3) & wb_sel_i[0];

    assign w_shifting  = (r_tap_state == ST_SHDR) || (r_tap_state == ST_SHIR);
    assign w_enter_cap = (w_tap_next == ST_CAPDR) || (w_tap_next == ST_CAPIR);
    assign w_enter_upd = (w_tap_next == ST_UPDDR) || (w_tap_next == ST_UPDIR);

    assign wb_err_o    = 1'b0;
    assign wb_rty_o    = 1'b0;

    // Control bits above [1] and the upper byte selects carry no meaning here.
    assign w_unused    = &{1'b0, wb_dat_i[31:2], wb_sel_i[3:1]};

    // Standard TMS-driven TAP transition graph.
    always_comb begin
        w_tap_next = ST_TLR;
        case (r_tap_state)
            ST_TLR:   w_tap_next = sr_tms_i ? ST_TLR   : ST_RTI;
            ST_RTI:   w_tap_next = sr_tms_i ? ST_SELDR : ST_RTI;
            ST_SELDR: w_tap_next = sr_tms_i ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: w_tap_next = sr_tms_i ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  w_tap_next = sr_tms_i ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: w_tap_next = sr_tms_i ? ST_UPDDR : ST_PSDR;
            ST_PSDR:  w_tap_next = sr_tms_i ? ST_EX2DR : ST_PSDR;
            ST_EX2DR: w_tap_next = sr_tms_i ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: w_tap_next = sr_tms_i ? ST_SELDR : ST_RTI;
            ST_SELIR: w_tap_next = sr_tms_i ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: w_tap_next = sr_tms_i ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  w_tap_next = sr_tms_i ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: w_tap_next = sr_tms_i ? ST_UPDIR : ST_PSIR;
            ST_PSIR:  w_tap_next = sr_tms_i ? ST_EX2IR : ST_PSIR;
            ST_EX2IR: w_tap_next = sr_tms_i ? ST_UPDIR : ST_SHIR;
            ST_UPDIR: w_tap_next = sr_tms_i ? ST_SELDR : ST_RTI;
            default:  w_tap_next = ST_TLR;
        endcase
    end

    // Status word; counters are fitted to their fixed 16/8-bit fields.
    always_comb begin
        w_status        = '0;
        w_status[3:0]   = 4'(r_tap_state);
        w_status[4]     = r_last_ir;
        w_status[15:8]  = 8'(r_upd_cnt);
        w_status[31:16] = 16'(r_bit_cnt);
    end

    always_comb begin
        w_rd_dat = '0;
        case (wb_adr_i)
            2'd0:    w_rd_dat = w_status;
            2'd1:    w_rd_dat = r_tdi_cap;
            2'd2:    w_rd_dat = r_tdo_cap;
            default: w_rd_dat = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_tap_state <= ST_TLR;
            r_clk_prev  <= 1'b1;
            r_tdi_cap   <= '0;
            r_tdo_cap   <= '0;
            r_bit_cnt   <= '0;
            r_upd_cnt   <= '0;
            r_last_ir   <= 1'b0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
        end else begin
            r_clk_prev <= sr_clk_i;
            wb_ack_o   <= w_select;

            // Read data reflects the state before this edge's tracker update.
            if (w_select && !wb_we_i) begin
                wb_dat_o <= w_rd_dat;
            end else begin
                wb_dat_o <= '0;
            end

            if (w_ctl_wr) begin
                // A software force/clear overrides a coincident TCK edge,
                // which is dropped entirely rather than half-applied.
                if (wb_dat_i[0]) begin
                    r_tap_state <= ST_TLR;
                end
                if (wb_dat_i[1]) begin
                    r_tdi_cap <= '0;
                    r_tdo_cap <= '0;
                    r_bit_cnt <= '0;
                    r_upd_cnt <= '0;
                    r_last_ir <= 1'b0;
                end
            end else if (w_tck_rise) begin
                r_tap_state <= w_tap_next;

                // The exiting edge (TMS=1) out of a shift state still shifts.
                if (w_shifting) begin
                    r_tdi_cap <= {sr_tdi_i, r_tdi_cap[31:1]};
                    r_tdo_cap <= {sr_tdo_i, r_tdo_cap[31:1]};
                    if (!(&r_bit_cnt)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_BITS'(1);
                    end
                end

                // Capture states are only reachable from SELDR/SELIR, so this
                // never collides with the shift above.
                if (w_enter_cap) begin
                    r_tdi_cap <= '0;
                    r_tdo_cap <= '0;
                    r_bit_cnt <= '0;
                    r_last_ir <= (w_tap_next == ST_CAPIR);
                end

                if (w_enter_upd) begin
                    r_upd_cnt <= r_upd_cnt + UPD_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rack_jtag_tap_tracker.sv
module tb_rack_jtag_tap_tracker;

    localparam int CNT_BITS = 10;
    localparam int UPD_BITS = 8;
    localparam int CMAX     = (1 << CNT_BITS) - 1;
    localparam int UMOD     = 1 << UPD_BITS;

    logic        wb_clk;
    logic        wb_rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        sr_clk_i;
    logic        sr_tms_i;
    logic        sr_tdi_i;
    logic        sr_tdo_i;

    rack_jtag_tap_tracker #(.CNT_BITS(CNT_BITS), .UPD_BITS(UPD_BITS)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .sr_clk_i (sr_clk_i),
        .sr_tms_i (sr_tms_i),
        .sr_tdi_i (sr_tdi_i),
        .sr_tdo_i (sr_tdo_i)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: TAP graph as lookup tables indexed by state code,
    // captures as a history of shifted bits.
    int nxt0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int m_state;
    int m_shifts;
    int m_upd;
    bit m_last_ir;
    bit m_tdi_q[$];
    bit m_tdo_q[$];

    function automatic void model_reset();
        m_state   = 15;
        m_shifts  = 0;
        m_upd     = 0;
        m_last_ir = 1'b0;
        m_tdi_q.delete();
        m_tdo_q.delete();
    endfunction

    function automatic void model_clear();
        m_shifts  = 0;
        m_upd     = 0;
        m_last_ir = 1'b0;
        m_tdi_q.delete();
        m_tdo_q.delete();
    endfunction

    function automatic void model_pulse(bit tms, bit tdi, bit tdo);
        int n;
        if (m_state == 2 || m_state == 10) begin
            m_tdi_q.push_back(tdi);
            m_tdo_q.push_back(tdo);
            if (m_tdi_q.size() > 32) begin
                void'(m_tdi_q.pop_front());
                void'(m_tdo_q.pop_front());
            end
            m_shifts++;
        end
        n = tms ? nxt1[m_state] : nxt0[m_state];
        if (n == 6 || n == 14) begin
            m_tdi_q.delete();
            m_tdo_q.delete();
            m_shifts  = 0;
            m_last_ir = (n == 14);
        end
        if (n == 5 || n == 13) m_upd = (m_upd + 1) % UMOD;
        m_state = n;
    endfunction

    // Newest bit lands at [31]; the k-th most recent bit at [32-k].
    function automatic logic [31:0] exp_cap(bit use_tdo);
        logic [31:0] v;
        int          n;
        v = '0;
        n = use_tdo ? m_tdo_q.size() : m_tdi_q.size();
        for (int k = 1; k <= n && k <= 32; k++)
            v[32-k] = use_tdo ? m_tdo_q[n-k] : m_tdi_q[n-k];
        return v;
    endfunction

    function automatic logic [31:0] exp_status();
        int bc;
        bc = (m_shifts > CMAX) ? CMAX : m_shifts;
        return 32'(m_state) | (32'(m_last_ir) << 4) | (32'(m_upd) << 8) | (32'(bc) << 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic wb_xfer(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        int t;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        t = 0;
        do begin
            step();
            t++;
        end while (!wb_ack_o && t < 8);
        check("wb_ack", {31'b0, wb_ack_o}, 32'd1);
        rd       = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        step();
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, d);
        check({tag, "_status"}, d, exp_status());
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, d);
        check({tag, "_tdi"}, d, exp_cap(1'b0));
        wb_xfer(1'b0, 2'd2, 32'h0, 4'hF, d);
        check({tag, "_tdo"}, d, exp_cap(1'b1));
    endtask

    task automatic tck_pulse(input bit tms, input bit tdi, input bit tdo);
        sr_clk_i = 1'b0;
        sr_tms_i = tms;
        sr_tdi_i = tdi;
        sr_tdo_i = tdo;
        step();
        sr_clk_i = 1'b1;
        step();
        model_pulse(tms, tdi, tdo);
    endtask

    // TCK rising edge landing in the same cycle as a bus select.
    task automatic tck_pulse_bus(input bit tms, input bit tdi, input bit tdo, input bit we,
                                 input logic [1:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, output logic [31:0] rd);
        sr_clk_i = 1'b0;
        sr_tms_i = tms;
        sr_tdi_i = tdi;
        sr_tdo_i = tdo;
        step();
        sr_clk_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        step();
        check("bus_edge_ack", {31'b0, wb_ack_o}, 32'd1);
        rd       = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        step();
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) tck_pulse(bits[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  tdi_b;
        logic [7:0]  tdo_b;
        bit          a, b, c;

        wb_rst   = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 2'd0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        sr_clk_i = 1'b1;
        sr_tms_i = 1'b0;
        sr_tdi_i = 1'b0;
        sr_tdo_i = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        wb_rst = 1'b0;
        // TCK already high at reset release: not an edge even with TMS=0.
        repeat (4) step();

        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, d);
        check("reset_status", d, 32'h0000000F);
        check("ack_one_cycle", {31'b0, wb_ack_o}, 32'd0);
        check("err_rty", {30'b0, wb_err_o, wb_rty_o}, 32'd0);

        // Held strobe: ack alternates.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 2'd0;
        step(); a = wb_ack_o;
        step(); b = wb_ack_o;
        step(); c = wb_ack_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        step();
        check("held_stb_pattern", {29'b0, a, b, c}, 32'b101);

        // To RTI, then five TMS=1 edges back to TLR.
        tck_pulse(1'b0, 1'b0, 1'b0);
        check_all("rti");
        tms_seq(8'b0001_1111, 5);
        check_all("five_ones");
        sr_tms_i = 1'b0;
        repeat (20) step();
        check_all("tck_held_high");

        // TLR -> SHDR, shift 0xA5 / 0x3C, exit on the last bit.
        tms_seq(8'b0000_0010, 4);
        check_all("to_shdr");
        tdi_b = 8'hA5;
        tdo_b = 8'h3C;
        for (int i = 0; i < 8; i++) tck_pulse(i == 7, tdi_b[i], tdo_b[i]);
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, d);
        check("tdi_a5", d, 32'hA500_0000);
        wb_xfer(1'b0, 2'd2, 32'h0, 4'hF, d);
        check("tdo_3c", d, 32'h3C00_0000);
        check_all("ex1dr");

        // Read in the same cycle as the update edge returns the pre-update status.
        check("pre_upd_state", exp_status(), 32'h0008_0001);
        tck_pulse_bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF, d);
        check("read_at_update", d, 32'h0008_0001);
        model_pulse(1'b1, 1'b0, 1'b0);
        check_all("upddr");

        // UPDDR -> SELDR -> SELIR -> CAPIR -> SHIR.
        tms_seq(8'b0000_0011, 4);
        check_all("shir");

        // Control write coincident with a shifting edge: force+clear win.
        tck_pulse_bus(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'h3, 4'h1, d);
        m_state = 15;
        model_clear();
        check_all("ctl_at_edge");

        // Same write without byte lane 0: ignored, the edge advances TLR -> RTI.
        tck_pulse_bus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h3, 4'hE, d);
        model_pulse(1'b0, 1'b0, 1'b0);
        check_all("ctl_sel0");

        // Saturation: RTI -> SHDR, shift well past 2^CNT_BITS-1 bits.
        tms_seq(8'b0000_0001, 3);
        for (int i = 0; i < CMAX + 80; i++)
            tck_pulse(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_all("saturate");

        // 2^UPD_BITS DR updates wrap the counter back to its start value.
        tms_seq(8'b0000_0011, 2);
        for (int i = 1; i < UMOD; i++) tms_seq(8'b0000_1101, 4);
        check_all("upd_wrap");
        check("upd_wrap_zero", (exp_status() >> 8) & 32'hFF, 32'd0);

        // Randomized TMS walk with random data, periodically compared.
        for (int i = 0; i < 300; i++) begin
            tck_pulse($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            if (i % 25 == 24) check_all("random");
        end

        // RO write ignored, control reads as zero, force-only and clear-only.
        wb_xfer(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, d);
        wb_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, d);
        check_all("ro_write");
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, d);
        check("ctl_read_zero", d, 32'd0);
        wb_xfer(1'b1, 2'd3, 32'h2, 4'h1, d);
        model_clear();
        check_all("clear_only");
        tms_seq(8'b0000_0010, 4);
        wb_xfer(1'b1, 2'd3, 32'h1, 4'h1, d);
        m_state = 15;
        check_all("force_only");

        // Synchronous reset mid-activity.
        tms_seq(8'b0000_0010, 4);
        wb_rst = 1'b1;
        step();
        wb_rst = 1'b0;
        model_reset();
        check_all("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
